// File: rtl/ahbl_pkg.sv
`default_nettype none
// ============================================================================
// ahbl_pkg : AHB-Lite encodings, FSM states and command record
// Rev 1.0
// ============================================================================
package ahbl_pkg;

  localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] c_HSIZE_BYTE = 3'b000;
  localparam logic [2:0] c_HSIZE_HALF = 3'b001;
  localparam logic [2:0] c_HSIZE_WORD = 3'b010;

  typedef enum logic {
    A_IDLE = 1'b0,
    A_BUSY = 1'b1
  } a_state_t;

  typedef enum logic {
    D_IDLE = 1'b0,
    D_BUSY = 1'b1
  } d_state_t;

  typedef struct packed {
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  function automatic logic [2:0] clamp_size(input logic [2:0] s);
    return (s > c_HSIZE_WORD) ? c_HSIZE_WORD : s;
  endfunction

  function automatic logic [31:0] align_addr(input logic [31:0] a, input logic [2:0] s);
    case (s)
      c_HSIZE_HALF: return {a[31:1], 1'b0};
      c_HSIZE_WORD: return {a[31:2], 2'b00};
      default:      return a;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// ============================================================================
// cmd_fifo : synchronous command queue with registered occupancy count
// Rev 1.0
// ============================================================================
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 68
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // A full queue refuses a push even when a pop happens on the same edge.
  assign w_push  = i_push && (r_count < CW'(DEPTH));
  assign w_pop   = i_pop && (r_count != '0);
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ahbl_cmd_master.sv
`default_nettype none
// ============================================================================
// ahbl_cmd_master : queued command interface driving a pipelined AHB-Lite master
// Rev 1.0
// ============================================================================
module ahbl_cmd_master
  import ahbl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [2:0]  cmd_size,
  output logic        rsp_valid,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  output logic        busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  cmd_t          w_push_cmd;
  cmd_t          w_head;
  logic [CW-1:0] w_count;
  logic          w_push_acc;
  logic          w_handoff;
  logic          w_complete;
  logic          w_next_nonempty;

  a_state_t      r_a_state, w_a_next;
  d_state_t      r_d_state, w_d_next;
  logic          r_d_write;
  logic [31:0]   r_d_wdata;
  logic          r_rsp_valid;
  logic          r_rsp_write;
  logic [31:0]   r_rsp_rdata;

  assign cmd_ready  = !HRESET && (w_count < CW'(FIFO_DEPTH));
  assign w_push_acc = cmd_valid && cmd_ready;
  assign w_push_cmd = '{write: cmd_write, size: clamp_size(cmd_size),
                        addr: cmd_addr, wdata: cmd_wdata};

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_cmd_fifo (
    .clk     (HCLK),
    .rst     (HRESET),
    .i_push  (w_push_acc),
    .i_pop   (w_handoff),
    .i_wdata (w_push_cmd),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  // HREADY high both retires the data phase and accepts the pending address phase.
  assign w_handoff  = (r_a_state == A_BUSY) && HREADY;
  assign w_complete = (r_d_state == D_BUSY) && HREADY;

  // Occupancy after this edge; the address FSM tracks it so NONSEQ follows a push directly.
  assign w_next_nonempty = w_push_acc || (w_count > CW'(1)) ||
                           ((w_count == CW'(1)) && !w_handoff);

  always_comb begin
    w_a_next = r_a_state;
    HTRANS   = c_HTRANS_IDLE;
    HADDR    = '0;
    HSIZE    = c_HSIZE_BYTE;
    HWRITE   = 1'b0;
    case (r_a_state)
      A_IDLE: begin
        if (w_next_nonempty) begin
          w_a_next = A_BUSY;
        end
      end
      A_BUSY: begin
        HTRANS = c_HTRANS_NONSEQ;
        HADDR  = align_addr(w_head.addr, w_head.size);
        HSIZE  = w_head.size;
        HWRITE = w_head.write;
        if (w_handoff && !w_next_nonempty) begin
          w_a_next = A_IDLE;
        end
      end
      default: w_a_next = A_IDLE;
    endcase
  end

  always_comb begin
    w_d_next = r_d_state;
    HWDATA   = '0;
    if (r_d_state == D_BUSY && r_d_write) begin
      HWDATA = r_d_wdata;
    end
    if (w_handoff) begin
      w_d_next = D_BUSY;
    end else if (w_complete) begin
      w_d_next = D_IDLE;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_a_state   <= A_IDLE;
      r_d_state   <= D_IDLE;
      r_d_write   <= 1'b0;
      r_d_wdata   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_a_state   <= w_a_next;
      r_d_state   <= w_d_next;
      if (w_handoff) begin
        r_d_write <= w_head.write;
        r_d_wdata <= w_head.wdata;
      end
      r_rsp_valid <= w_complete;
      r_rsp_write <= w_complete && r_d_write;
      r_rsp_rdata <= (w_complete && !r_d_write) ? HRDATA : '0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_write = r_rsp_write;
  assign rsp_rdata = r_rsp_rdata;
  assign busy      = (w_count != '0) || (r_a_state == A_BUSY) || (r_d_state == D_BUSY);

endmodule
`default_nettype wire

// File: tb/tb_ahbl_cmd_master.sv
`default_nettype none
// ============================================================================
// tb_ahbl_cmd_master : directed self-checking bench for ahbl_cmd_master
// Rev 1.0
// ============================================================================
module tb_ahbl_cmd_master;

  logic        HCLK;
  logic        HRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        w;
    logic [31:0] d;
  } rsp_t;
  rsp_t        rq[$];
  logic [31:0] aq[$];

  ahbl_cmd_master #(.FIFO_DEPTH(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .busy(busy)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Log responses and accepted address phases in the middle of each cycle.
  always @(negedge HCLK) begin
    if (rsp_valid === 1'b1) rq.push_back('{w: rsp_write, d: rsp_rdata});
    if (HTRANS === 2'b10 && HREADY === 1'b1) aq.push_back(HADDR);
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_cmd(input logic v, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] s);
    cmd_valid = v; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_size = s;
  endtask

  task automatic test_reset();
    HRESET = 1'b1; HREADY = 1'b1; HRDATA = '0;
    set_cmd(1'b0, 1'b0, '0, '0, 3'd0);
    step(); step();
    n_tests++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
    n_tests++; if (HTRANS !== 2'b00) begin n_fail++; $display("FAIL rst_htrans: got %b want 00", HTRANS); end
    n_tests++; if (HADDR !== 32'h0 || HSIZE !== 3'd0 || HWRITE !== 1'b0) begin n_fail++; $display("FAIL rst_addr_phase: got %h/%0d/%b want 0/0/0", HADDR, HSIZE, HWRITE); end
    n_tests++; if (HWDATA !== 32'h0) begin n_fail++; $display("FAIL rst_hwdata: got %h want 0", HWDATA); end
    n_tests++; if (rsp_valid !== 1'b0 || rsp_write !== 1'b0 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rsp: got %b/%b/%h want 0/0/0", rsp_valid, rsp_write, rsp_rdata); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    HRESET = 1'b0;
    #1;
    n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_single_write();
    HREADY = 1'b1;
    set_cmd(1'b1, 1'b1, 32'h0100_0004, 32'hDEAD_BEEF, 3'd2);
    step();
    cmd_valid = 1'b0;
    n_tests++; if (HTRANS !== 2'b10) begin n_fail++; $display("FAIL wr_nonseq: got %b want 10", HTRANS); end
    n_tests++; if (HADDR !== 32'h0100_0004 || HWRITE !== 1'b1 || HSIZE !== 3'd2) begin n_fail++; $display("FAIL wr_addr_phase: got %h/%b/%0d want 01000004/1/2", HADDR, HWRITE, HSIZE); end
    step();
    n_tests++; if (HWDATA !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_hwdata: got %h want deadbeef", HWDATA); end
    n_tests++; if (HTRANS !== 2'b00) begin n_fail++; $display("FAIL wr_idle_after: got %b want 00", HTRANS); end
    step();
    n_tests++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_rsp: got %b/%b/%h want 1/1/0", rsp_valid, rsp_write, rsp_rdata); end
    step();
    n_tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL wr_pulse_end: got valid %b busy %b want 0 0", rsp_valid, busy); end
  endtask

  task automatic test_single_read();
    HREADY = 1'b1; HRDATA = 32'hABCD_EF00;
    set_cmd(1'b1, 1'b0, 32'h0000_0000, 32'h0, 3'd2);
    step();
    cmd_valid = 1'b0;
    n_tests++; if (HTRANS !== 2'b10 || HWRITE !== 1'b0) begin n_fail++; $display("FAIL rd_nonseq: got %b/%b want 10/0", HTRANS, HWRITE); end
    step();
    n_tests++; if (HWDATA !== 32'h0) begin n_fail++; $display("FAIL rd_hwdata: got %h want 0", HWDATA); end
    step();
    n_tests++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_rdata !== 32'hABCD_EF00) begin n_fail++; $display("FAIL rd_rsp: got %b/%b/%h want 1/0/abcdef00", rsp_valid, rsp_write, rsp_rdata); end
    step();
    HRDATA = '0;
  endtask

  task automatic test_size_align();
    HREADY = 1'b1;
    set_cmd(1'b1, 1'b1, 32'h0000_0123, 32'h1, 3'd7);
    step();
    set_cmd(1'b1, 1'b1, 32'h0000_0013, 32'h2, 3'd1);
    n_tests++; if (HSIZE !== 3'd2 || HADDR !== 32'h0000_0120) begin n_fail++; $display("FAIL clamp_word: got %0d/%h want 2/00000120", HSIZE, HADDR); end
    step();
    cmd_valid = 1'b0;
    n_tests++; if (HTRANS !== 2'b10 || HSIZE !== 3'd1 || HADDR !== 32'h0000_0012) begin n_fail++; $display("FAIL align_half: got %b/%0d/%h want 10/1/00000012", HTRANS, HSIZE, HADDR); end
    step(); step(); step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [4];
    rq.delete();
    HREADY = 1'b1;
    for (int i = 0; i < 4; i++) d[i] = 32'h1111_1111 * (i + 1);
    for (int k = 0; k < 6; k++) begin
      if (k < 4) set_cmd(1'b1, 1'b1, 32'(k) << 24, d[k], 3'd2);
      else cmd_valid = 1'b0;
      step();
      if (k < 4) begin
        n_tests++; if (HTRANS !== 2'b10 || HADDR !== (32'(k) << 24)) begin n_fail++; $display("FAIL b2b_addr%0d: got %b/%h want 10/%h", k, HTRANS, HADDR, 32'(k) << 24); end
      end
      if (k >= 1 && k <= 4) begin
        n_tests++; if (HWDATA !== d[k-1]) begin n_fail++; $display("FAIL b2b_wdata%0d: got %h want %h", k - 1, HWDATA, d[k-1]); end
      end
      if (k >= 2) begin
        n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_rsp%0d: got %b want 1", k - 2, rsp_valid); end
      end
    end
    step();
    n_tests++; if (rq.size() != 4) begin n_fail++; $display("FAIL b2b_rsp_count: got %0d want 4", rq.size()); end
  endtask

  task automatic test_wait_states();
    rq.delete();
    HREADY = 1'b1;
    set_cmd(1'b1, 1'b1, 32'h0000_0040, 32'h5555_AAAA, 3'd2);
    step();
    set_cmd(1'b1, 1'b0, 32'h0000_0080, 32'h0, 3'd2);
    step();
    cmd_valid = 1'b0;
    HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (HTRANS !== 2'b10 || HADDR !== 32'h0000_0080 || HWDATA !== 32'h5555_AAAA) begin n_fail++; $display("FAIL wait_hold%0d: got %b/%h/%h want 10/00000080/5555aaaa", i, HTRANS, HADDR, HWDATA); end
      n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wait_no_rsp%0d: got %b want 0", i, rsp_valid); end
    end
    HREADY = 1'b1; HRDATA = 32'h1234_5678;
    step();
    n_tests++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || HTRANS !== 2'b00) begin n_fail++; $display("FAIL wait_first_done: got %b/%b/%b want 1/1/00", rsp_valid, rsp_write, HTRANS); end
    step();
    n_tests++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL wait_second_done: got %b/%b/%h want 1/0/12345678", rsp_valid, rsp_write, rsp_rdata); end
    step();
    HRDATA = '0;
  endtask

  task automatic test_fifo_full();
    rq.delete(); aq.delete();
    HREADY = 1'b0; HRDATA = 32'h0000_00C3;
    for (int i = 0; i < 4; i++) begin
      set_cmd(1'b1, 1'b0, 32'h0000_1000 + 32'(4 * i), 32'h0, 3'd2);
      step();
    end
    n_tests++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", cmd_ready); end
    set_cmd(1'b1, 1'b0, 32'h0000_2000, 32'h0, 3'd2);
    HREADY = 1'b1;
    step();
    cmd_valid = 1'b0;
    n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_pop: got %b want 1", cmd_ready); end
    for (int i = 0; i < 6; i++) step();
    n_tests++; if (rq.size() != 4 || aq.size() != 4) begin n_fail++; $display("FAIL full_refused: got %0d rsp %0d addr want 4 4", rq.size(), aq.size()); end
    else begin
      n_tests++; if (aq[3] !== 32'h0000_100C || rq[3].d !== 32'h0000_00C3) begin n_fail++; $display("FAIL full_last: got %h/%h want 0000100c/000000c3", aq[3], rq[3].d); end
    end
    HRDATA = '0;
  endtask

  task automatic test_reset_midflight();
    HREADY = 1'b1;
    set_cmd(1'b1, 1'b1, 32'h0000_0500, 32'hA5A5_0001, 3'd2);
    step();
    set_cmd(1'b1, 1'b1, 32'h0000_0504, 32'hA5A5_0002, 3'd2);
    step();
    set_cmd(1'b1, 1'b1, 32'h0000_0508, 32'hA5A5_0003, 3'd2);
    HREADY = 1'b0;
    step();
    cmd_valid = 1'b0;
    n_tests++; if (busy !== 1'b1 || HWDATA !== 32'hA5A5_0001) begin n_fail++; $display("FAIL midrst_setup: got busy %b hwdata %h want 1 a5a50001", busy, HWDATA); end
    HRESET = 1'b1;
    step();
    rq.delete();
    n_tests++; if (HTRANS !== 2'b00 || busy !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got %b/%b/%b want 00/0/0", HTRANS, busy, rsp_valid); end
    HRESET = 1'b0; HREADY = 1'b1;
    for (int i = 0; i < 4; i++) step();
    n_tests++; if (rq.size() != 0 || HTRANS !== 2'b00) begin n_fail++; $display("FAIL midrst_discard: got %0d rsp htrans %b want 0 00", rq.size(), HTRANS); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_size_align();
    test_back_to_back();
    test_wait_states();
    test_fifo_full();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahbl_cmd_master.md
AHBL_CMD_MASTER -- requirements
Module: ahbl_cmd_master

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning command FIFO entries; power of two, 2..16.
REQ-002 SHALL have port HCLK  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port HRESET  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_write in 1, cmd_addr in 32, cmd_wdata in 32, cmd_size in 3 (command push handshake).
REQ-005 SHALL have ports rsp_valid out 1, rsp_write out 1, rsp_rdata out 32 (one-cycle completion pulse, no backpressure).
REQ-006 SHALL have AHB-Lite master ports HADDR out 32, HTRANS out 2, HSIZE out 3, HWRITE out 1, HWDATA out 32, HREADY in 1, HRDATA in 32.
REQ-007 SHALL have port busy  out 1  high when the FIFO is non-empty or any bus phase is outstanding.

Function
REQ-008 SHALL accept a command when cmd_valid and cmd_ready are both high at a rising edge.
REQ-009 SHALL drive cmd_ready = (FIFO count < FIFO_DEPTH), from registered count only; push into a full FIFO is refused even if a pop occurs in the same cycle.
REQ-010 SHALL clamp cmd_size values above 3'b010 to 3'b010 at push.
REQ-011 SHALL force HADDR low bits to zero per HSIZE: [0] for halfword, [1:0] for word.
REQ-012 SHALL use address-phase FSM states A_IDLE (HTRANS=2'b00) and A_BUSY (HTRANS=2'b10 NONSEQ, head command on HADDR/HSIZE/HWRITE).
REQ-013 SHALL move A_IDLE->A_BUSY when the FIFO is non-empty; earliest NONSEQ is the cycle after the push (no bypass).
REQ-014 SHALL hold HADDR, HTRANS, HSIZE, HWRITE stable in A_BUSY while HREADY is low.
REQ-015 SHALL pop the FIFO head and hand the transfer to the data phase at each edge with A_BUSY and HREADY high; next entry presents immediately (back-to-back NONSEQ), else A_IDLE.
REQ-016 SHALL use data-phase states D_IDLE and D_BUSY; D_BUSY holds write flag and wdata of the transfer in its data phase.
REQ-017 SHALL drive HWDATA from the D_BUSY write data, stable until HREADY high; HWDATA = 0 in D_IDLE or for reads.
REQ-018 SHALL complete the data phase at the first edge in D_BUSY with HREADY high; reads capture HRDATA at that edge.
REQ-019 SHALL pulse rsp_valid for exactly one cycle, the cycle after completion, with rsp_write = transfer direction and rsp_rdata = captured HRDATA (0 for writes).
REQ-020 SHALL return responses in command order, at most one per cycle; sustained throughput one transfer per cycle with HREADY constantly high.
REQ-021 SHALL, on simultaneous address-phase acceptance and data-phase completion, load D_BUSY with the new transfer in the same edge, with no bubble.

Reset
REQ-022 SHALL, while HRESET is high at an edge, set: FIFO empty, both FSMs idle, HTRANS=00, HADDR=0, HSIZE=0, HWRITE=0, HWDATA=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, busy=0; cmd_ready=0 while HRESET is high, 1 after.
REQ-023 SHALL, on reset mid-transfer, discard all queued and in-flight commands with no rsp_valid for them.

Structure
REQ-024 SHALL place HTRANS encodings (IDLE=2'b00, NONSEQ=2'b10), HSIZE encodings (BYTE/HALF/WORD) and FSM state encodings in shared package ahbl_pkg.
REQ-025 SHALL implement the command queue as sub-module cmd_fifo (synchronous, registered count, width 68 bits: write+size+addr+wdata).

Verification
REQ-026 SHALL test: push write addr 0x0100_0004 data 0xDEAD_BEEF size 2, HREADY=1 -> NONSEQ one cycle later, HWDATA=0xDEAD_BEEF next cycle, rsp_valid pulse with rsp_write=1.
REQ-027 SHALL test: push read addr 0x0000_0000, slave HRDATA=0xABCD_EF00, HREADY=1 -> rsp_rdata=0xABCD_EF00, rsp_write=0.
REQ-028 SHALL test: 4 writes back-to-back to 0x0000_0000/0x0100_0000/0x0200_0000/0x0300_0000 -> four consecutive NONSEQ cycles, four in-order responses.
REQ-029 SHALL test: HREADY low 3 cycles during a write data phase with a second command queued -> HADDR/HWDATA held stable, second NONSEQ waits, correct completion order.
REQ-030 SHALL test: fill FIFO (4 pushes with HREADY=0) -> cmd_ready=0; 5th push with a concurrent pop is refused; cmd_ready=1 one cycle after the pop.
REQ-031 SHALL test: HRESET asserted while 2 transfers are queued and 1 is in data phase -> HTRANS=00 next cycle, no rsp_valid, busy=0.
